// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants, round-constant lookup and walker state encoding.
// Pure declarations: no latency, no flow control.
package aes_pkg;

  localparam int KEY_LEN  = 128;
  localparam int WORD_LEN = 32;
  localparam int NR       = 10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Round constant byte for rounds 1..10; it lands in the top byte of the word.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/inv_key_schedule_if.sv
// Key-load and round-key output bundle; master drives loads and ready_out, slave is the walker.
// Valid/ready on both sides; the slave never retracts valid_out.
interface inv_key_schedule_if;
  import aes_pkg::*;

  logic               valid_in;
  logic               ready_in;
  logic [KEY_LEN-1:0] data_in;
  logic [KEY_LEN-1:0] data_out;
  logic [3:0]         round_out;
  logic               valid_out;
  logic               ready_out;
  logic               last_out;

  modport master (
    output valid_in, data_in, ready_out,
    input  ready_in, data_out, round_out, valid_out, last_out
  );

  modport slave (
    input  valid_in, data_in, ready_out,
    output ready_in, data_out, round_out, valid_out, last_out
  );

endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational; shared with the forward sub-key generator.
// Zero latency, no flow control.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so the bit offset is (255 - a) * 8.
  assign y = SBOX[{~a, 3'b000} +: 8];

endmodule

// File: rtl/inv_key_schedule.sv
// Reverse AES-128 key-schedule walker: load key NR, emit keys NR..0, one per handshake.
// First key one cycle after load; one key per cycle under ready_out, held stable while stalled.
module inv_key_schedule
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  inv_key_schedule_if.slave    bus
);

  state_e               state_q, state_d;
  logic [KEY_LEN-1:0]   key_q, key_d;
  logic [3:0]           round_q, round_d;

  logic [WORD_LEN-1:0]  w0, w1, w2, w3;
  logic [WORD_LEN-1:0]  p0, p1, p2, p3;
  logic [WORD_LEN-1:0]  rot_w, sub_w;

  assign {w0, w1, w2, w3} = key_q;

  // Undo the forward XOR chain first; the recovered w3 of the previous key feeds SubWord.
  assign p3    = w3 ^ w2;
  assign p2    = w2 ^ w1;
  assign p1    = w1 ^ w0;
  assign rot_w = {p3[23:0], p3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .a (rot_w[8*i +: 8]),
      .y (sub_w[8*i +: 8])
    );
  end

  assign p0 = w0 ^ sub_w ^ {rcon(round_q), 24'h000000};

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    case (state_q)
      IDLE: begin
        if (bus.valid_in) begin
          key_d   = bus.data_in;
          round_d = 4'(NR);
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (bus.ready_out) begin
          if (round_q == 4'd0) begin
            state_d = IDLE;
          end else begin
            key_d   = {p0, p1, p2, p3};
            round_d = round_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
    end
  end

  assign bus.ready_in  = (state_q == IDLE);
  assign bus.valid_out = (state_q == EMIT);
  assign bus.data_out  = key_q;
  assign bus.round_out = round_q;
  assign bus.last_out  = (state_q == EMIT) && (round_q == 4'd0);

endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for inv_key_schedule: FIPS-197 walk, backpressure, busy loads, reset abort.
module tb_inv_key_schedule;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   rnd;
    logic         last;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  int           n_vec = 0;
  int           n_err = 0;
  exp_t         sb[$];
  logic [127:0] fips [0:10];
  logic         fips_mode;
  logic         have_prev;
  logic [127:0] prev_key;
  logic [3:0]   prev_rnd;
  int           waited;

  always #5 clk = ~clk;

  inv_key_schedule_if bus();

  inv_key_schedule dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Independent reference: S-box built from GF(2^8) inversion plus the affine map.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_m(input logic [7:0] a);
    logic [7:0] b;
    b = 8'h01;
    for (int i = 0; i < 254; i++) b = gmul(b, a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] t_word(input logic [31:0] w, input int r);
    logic [31:0] rot;
    logic [7:0]  rc;
    rot = {w[23:0], w[31:24]};
    rc  = 8'h01;
    for (int i = 1; i < r; i++) rc = xtime(rc);
    return {sbox_m(rot[31:24]) ^ rc, sbox_m(rot[23:16]), sbox_m(rot[15:8]), sbox_m(rot[7:0])};
  endfunction

  function automatic logic [127:0] fwd_step(input logic [127:0] k, input int r);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ t_word(k[31:0], r);
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] inv_step_m(input logic [127:0] k, input int r);
    logic [31:0] q0, q1, q2, q3;
    q3 = k[31:0] ^ k[63:32];
    q2 = k[63:32] ^ k[95:64];
    q1 = k[95:64] ^ k[127:96];
    q0 = k[127:96] ^ t_word(q3, r);
    return {q0, q1, q2, q3};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_walk(input logic [127:0] k10);
    logic [127:0] k;
    exp_t e;
    k = k10;
    for (int r = 10; r >= 0; r--) begin
      e.key  = k;
      e.rnd  = 4'(r);
      e.last = (r == 0);
      sb.push_back(e);
      if (r > 0) k = inv_step_m(k, r);
    end
    have_prev = 1'b0;
  endtask

  task automatic load(input logic [127:0] k);
    chk("ready_in_before_load", {127'd0, bus.ready_in}, 128'd1);
    bus.valid_in = 1'b1;
    bus.data_in  = k;
    tick();
    bus.valid_in = 1'b0;
    push_walk(k);
  endtask

  // Consume one key; with rand_bp, ready_out toggles randomly before the transfer.
  task automatic take(input bit rand_bp, output int n);
    bit   rdy;
    exp_t e;
    n = 0;
    while (n < 64) begin
      rdy = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.ready_out = rdy;
      if (bus.valid_out && rdy) break;
      tick();
      n++;
    end
    if (n >= 64) begin
      chk("take_timeout", {127'd0, bus.valid_out}, 128'd1);
    end else if (sb.size() == 0) begin
      chk("unexpected_key", {127'd0, bus.valid_out}, 128'd0);
      tick();
    end else begin
      e = sb.pop_front();
      chk("key", bus.data_out, e.key);
      chk("round", {124'd0, bus.round_out}, {124'd0, e.rnd});
      chk("last", {127'd0, bus.last_out}, {127'd0, e.last});
      if (fips_mode) chk("fips_key", bus.data_out, fips[bus.round_out]);
      if (have_prev) chk("round_trip", fwd_step(bus.data_out, int'(prev_rnd)), prev_key);
      have_prev = 1'b1;
      prev_key  = bus.data_out;
      prev_rnd  = bus.round_out;
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] key_x;
    logic [127:0] key_y;
    fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    key_x = {$urandom, $urandom, $urandom, $urandom};
    key_y = {$urandom, $urandom, $urandom, $urandom};

    reset         = 1'b1;
    bus.valid_in  = 1'b0;
    bus.data_in   = '0;
    bus.ready_out = 1'b0;
    fips_mode     = 1'b0;
    have_prev     = 1'b0;
    prev_key      = '0;
    prev_rnd      = '0;
    tick();
    tick();
    chk("rst_ready_in", {127'd0, bus.ready_in}, 128'd1);
    chk("rst_valid_out", {127'd0, bus.valid_out}, 128'd0);
    chk("rst_last_out", {127'd0, bus.last_out}, 128'd0);
    chk("rst_data_out", bus.data_out, 128'd0);
    chk("rst_round_out", {124'd0, bus.round_out}, 128'd0);
    reset = 1'b0;
    tick();

    // FIPS-197 A.1 walk with ready_out held high: eleven back-to-back keys.
    fips_mode     = 1'b1;
    bus.ready_out = 1'b1;
    load(fips[10]);
    for (int i = 0; i < 11; i++) begin
      take(1'b0, waited);
      chk("no_bubble", 128'(waited), 128'd0);
    end
    chk("idle_ready_in", {127'd0, bus.ready_in}, 128'd1);
    chk("idle_valid_out", {127'd0, bus.valid_out}, 128'd0);

    // Stall at round 7 while a different key is offered; the offer stays up to the end.
    load(fips[10]);
    for (int i = 0; i < 3; i++) take(1'b0, waited);
    bus.ready_out = 1'b0;
    bus.valid_in  = 1'b1;
    bus.data_in   = key_x;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid_out", {127'd0, bus.valid_out}, 128'd1);
      chk("bp_round_out", {124'd0, bus.round_out}, 128'd7);
      chk("bp_data_out", bus.data_out, fips[7]);
      chk("bp_ready_in", {127'd0, bus.ready_in}, 128'd0);
    end
    for (int i = 0; i < 8; i++) take(1'b0, waited);
    chk("held_idle_ready_in", {127'd0, bus.ready_in}, 128'd1);
    chk("held_idle_valid_out", {127'd0, bus.valid_out}, 128'd0);
    chk("sb_drained", 128'(sb.size()), 128'd0);

    // The still-asserted offer is taken on this IDLE cycle, exactly once.
    fips_mode = 1'b0;
    push_walk(key_x);
    tick();
    bus.valid_in = 1'b0;
    for (int i = 0; i < 11; i++) take(1'b1, waited);
    chk("rand_walk_ready_in", {127'd0, bus.ready_in}, 128'd1);

    // Abort at round 4, then restart from a fresh key.
    fips_mode     = 1'b1;
    bus.ready_out = 1'b1;
    load(fips[10]);
    for (int i = 0; i < 6; i++) take(1'b0, waited);
    chk("pre_reset_round", {124'd0, bus.round_out}, 128'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_valid_out", {127'd0, bus.valid_out}, 128'd0);
    chk("abort_data_out", bus.data_out, 128'd0);
    chk("abort_ready_in", {127'd0, bus.ready_in}, 128'd1);
    chk("abort_round_out", {124'd0, bus.round_out}, 128'd0);
    chk("abort_last_out", {127'd0, bus.last_out}, 128'd0);
    sb.delete();
    fips_mode = 1'b0;
    load(key_y);
    for (int i = 0; i < 11; i++) take(1'b1, waited);
    tick();
    chk("end_valid_out", {127'd0, bus.valid_out}, 128'd0);
    chk("end_sb_empty", 128'(sb.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inv_key_schedule.md
Name: inv_key_schedule

Overview:
- Reverse AES-128 key-schedule walker for the decryption datapath.
- Accepts the final round key (round NR) and produces round keys NR, NR-1, ..., 0, one per handshake, each tagged with its round index.
- Each step is the exact inverse of the forward one-round sub-key generator, so the inverse cipher consumes keys in the order it needs them without storing the whole expanded schedule.
- Sits between the key-load interface and the inverse-round pipeline.

Parameters:
- KEY_LEN, 128, round key width in bits (only 128 supported).
- WORD_LEN, 32, key word width in bits; KEY_LEN/WORD_LEN = 4 words.
- NR, 10, number of rounds; the first emitted round index.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_in  input  1  data_in holds a final round key to load.
- ready_in  output  1  block is IDLE and can accept a load.
- data_in  input  KEY_LEN  round-NR key; word 0 is in bits [127:96].
- data_out  output  KEY_LEN  current round key.
- round_out  output  4  round index of data_out (NR down to 0).
- valid_out  output  1  data_out/round_out are valid.
- ready_out  input  1  downstream accepts the current key.
- last_out  output  1  asserted with valid_out when round_out == 0.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous and active-high; ports are named clk and reset as elsewhere in the codebase.
- Reset values:
  - State IDLE.
  - ready_in=1, valid_out=0, last_out=0.
  - data_out=0, round_out=0.
- States: IDLE and EMIT.
- IDLE:
  - ready_in=1, valid_out=0.
  - On valid_in=1: key register <= data_in, round register <= NR, go to EMIT.
- EMIT:
  - ready_in=0; valid_in is ignored and nothing is latched.
  - valid_out=1; data_out = key register; round_out = round register.
  - last_out = (round==0).
- Handshake:
  - A transfer occurs when valid_out && ready_out.
  - With ready_out=0, data_out, round_out and valid_out hold stable (AXI-style; no retraction).
- On transfer with round>0:
  - key <= inv_step(key, Rcon[round]).
  - round <= round-1.
  - Stay in EMIT.
- On transfer with round==0: go to IDLE.
  - ready_in=1 on the next cycle.
  - A new load is possible that cycle, so the minimum gap between loads is 1 cycle of ready_in.
- Latency:
  - First key appears the cycle after load acceptance.
  - With ready_out held high, the 11 keys are emitted on 11 consecutive cycles.
- inv_step, with words w0..w3 of the current key (w0 = MSW), produces p0..p3:
  - p3 = w3^w2, p2 = w2^w1, p1 = w1^w0.
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ Rcon[round].
  - RotWord is a rotate left by one byte.
  - SubWord is the forward S-box per byte.
- Rcon table: Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36 in the MSB byte; the low 24 bits are zero.
- Register use: inv_step is combinational from the key register, so there is exactly one register stage per step.
- Reset mid-operation: aborts the sequence next edge, with all outputs at reset values; no partial key is emitted afterwards.
- Simultaneous valid_in and a final transfer (round 0): valid_in is not accepted that cycle, because ready_in is 0; it is accepted on the following IDLE cycle if still asserted.
- Other valid_in behaviour: a valid_in held high across IDLE loads exactly once per IDLE entry.
- Round counter: never wraps below 0; round 0 always exits to IDLE.

Decomposition:
- Shared package aes_pkg holds:
  - KEY_LEN, WORD_LEN, NR.
  - The Rcon function/table, shared with the forward sub-key generator.
  - The state enum {IDLE, EMIT}.
- One sub-module, aes_sbox: combinational 8-bit forward S-box, instantiated 4 times for SubWord.
  - It is the same S-box the forward generator uses and is not duplicated.

Test Plan:
- FIPS-197 A.1 load:
  - Stimulus: data_in=d014f9a8c9ee2589e13f0cc8b6630ca6, valid_in=1, ready_out=1.
  - Response: the next cycle shows round_out=10 with that key; the following cycle shows round_out=9, data_out=ac7766f319fadc2128d12941575c006e.
- Full walk:
  - Stimulus: same load, ready_out=1 throughout.
  - Response: round_out=1 gives a0fafe1788542cb123a339392a6c7605; round_out=0 gives 2b7e151628aed2a6abf7158809cf4f3c with last_out=1; ready_in=1 on the next cycle.
- Backpressure:
  - Stimulus: ready_out=0 for 5 cycles while round_out=7.
  - Response: data_out and round_out are unchanged and valid_out=1 throughout; the sequence resumes correctly to round 0.
- Load while busy:
  - Stimulus: valid_in=1 with a different key during EMIT.
  - Response: ignored; the sequence still ends with 2b7e1516...4f3c.
- Reset mid-walk:
  - Stimulus: assert reset for 1 cycle at round_out=4.
  - Response: next cycle valid_out=0, data_out=0, ready_in=1; a fresh load restarts at round 10.
- Round-trip check:
  - Stimulus: feed each emitted key k_{r-1} with Rcon[r] into the forward sub-key generator.
  - Response: the generator reproduces k_r for all r=1..10.
